// File: rtl/dma_multichannel_engine.sv
// Multi-channel device-to-memory DMA: per-channel line commands, round-robin
// arbitration, bursts of up to MAX_BURST cache lines per BR/BG bus grant.
module dma_multichannel_engine #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_CH      = 2,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int MAX_BURST   = 4,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                   Clk,
  input  logic                                   Reset_N,
  input  logic                                   cmd_valid,
  input  logic [CH_W-1:0]                        cmd_ch,
  input  logic [WORD_SIZE-1:0]                   cmd_addr,
  input  logic [WORD_SIZE-1:0]                   cmd_len,
  output logic                                   cmd_ready,
  output logic                                   BR,
  input  logic                                   BG,
  output logic [WORD_SIZE-1:0]                   d_address,
  output logic                                   d_writeM,
  output logic [LINE_WORDS*WORD_SIZE-1:0]        d_data,
  input  logic [NUM_CH*LINE_WORDS*WORD_SIZE-1:0] dev_data,
  output logic [NUM_CH-1:0]                      dev_ack,
  output logic [NUM_CH-1:0]                      busy,
  output logic [NUM_CH-1:0]                      dma_end_int
);

  localparam int          LINE_BITS = LINE_WORDS * WORD_SIZE;
  localparam int          BEAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int          BURST_W   = $clog2(MAX_BURST + 1);
  localparam int unsigned NCH       = NUM_CH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] XFER    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]           state;
  logic [CH_W-1:0]      sel_ch;
  logic [CH_W-1:0]      last_served;
  logic [CH_W-1:0]      pick_ch;
  logic                 pick_valid;
  logic [BEAT_W-1:0]    beat;
  logic [BURST_W-1:0]   burst;
  logic [WORD_SIZE-1:0] addr_q [NUM_CH];
  logic [WORD_SIZE-1:0] rem_q  [NUM_CH];
  logic [(1<<CH_W)-1:0] busy_pad;
  logic                 accept;
  logic                 xfer_on;
  logic                 line_done;

  // Padding keeps cmd_ch/rotation lookups in range for non-power-of-two NUM_CH.
  always_comb begin
    busy_pad             = '0;
    busy_pad[NUM_CH-1:0] = busy;
  end

  assign cmd_ready = !busy_pad[cmd_ch];
  assign accept    = cmd_valid && cmd_ready;
  assign BR        = (state == REQ) || (state == XFER);
  assign xfer_on   = (state == XFER) && BG;
  assign d_writeM  = xfer_on;
  assign line_done = xfer_on && (beat == BEAT_W'(MEM_LATENCY - 1));

  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!pick_valid && busy_pad[CH_W'((32'(last_served) + i) % NCH)]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'((32'(last_served) + i) % NCH);
      end
    end
  end

  always_comb begin
    d_address = '0;
    d_data    = '0;
    dev_ack   = '0;
    if (state == XFER) begin
      d_address = addr_q[sel_ch];
      for (int unsigned c = 0; c < NCH; c++) begin
        if (CH_W'(c) == sel_ch) d_data = dev_data[c*LINE_BITS +: LINE_BITS];
      end
    end
    if (line_done) dev_ack[sel_ch] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= IDLE;
      sel_ch      <= '0;
      last_served <= CH_W'(NUM_CH - 1);
      beat        <= '0;
      burst       <= '0;
      busy        <= '0;
      dma_end_int <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
    end else begin
      dma_end_int <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel_ch <= pick_ch;
            state  <= REQ;
          end
        end
        REQ: begin
          if (BG) begin
            state <= XFER;
            beat  <= '0;
            burst <= '0;
          end
        end
        XFER: begin
          // Losing the grant discards the partial line; it restarts on regrant.
          if (!BG) begin
            state <= REQ;
            beat  <= '0;
          end else if (line_done) begin
            addr_q[sel_ch] <= addr_q[sel_ch] + WORD_SIZE'(LINE_WORDS);
            rem_q[sel_ch]  <= rem_q[sel_ch] - WORD_SIZE'(1);
            burst          <= burst + BURST_W'(1);
            beat           <= '0;
            if (rem_q[sel_ch] == WORD_SIZE'(1)) begin
              busy[sel_ch]        <= 1'b0;
              dma_end_int[sel_ch] <= 1'b1;
              state               <= RELEASE;
            end else if (burst == BURST_W'(MAX_BURST - 1)) begin
              state <= RELEASE;
            end
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        RELEASE: begin
          last_served <= sel_ch;
          if (!BG) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Accepted channel is never the active one, so this cannot collide with XFER updates.
      if (accept) begin
        addr_q[cmd_ch] <= cmd_addr;
        rem_q[cmd_ch]  <= cmd_len;
        if (cmd_len == '0) dma_end_int[cmd_ch] <= 1'b1;
        else               busy[cmd_ch]        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_multichannel_engine.sv
// Self-checking bench for dma_multichannel_engine: directed scenarios plus
// randomized two-channel runs against a line-level round-robin model.
module tb_dma_multichannel_engine;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int LW = 4;
  localparam int ML = 4;
  localparam int MB = 4;
  localparam int LB = LW * W;

  logic            Clk = 1'b0;
  logic            Reset_N = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [0:0]      cmd_ch = '0;
  logic [W-1:0]    cmd_addr = '0;
  logic [W-1:0]    cmd_len = '0;
  logic            cmd_ready;
  logic            BR;
  logic            BG = 1'b0;
  logic [W-1:0]    d_address;
  logic            d_writeM;
  logic [LB-1:0]   d_data;
  logic [N*LB-1:0] dev_data = '0;
  logic [N-1:0]    dev_ack;
  logic [N-1:0]    busy;
  logic [N-1:0]    dma_end_int;

  dma_multichannel_engine #(
    .WORD_SIZE(W), .NUM_CH(N), .LINE_WORDS(LW), .MEM_LATENCY(ML), .MAX_BURST(MB)
  ) dut (
    .Clk(Clk), .Reset_N(Reset_N), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready), .BR(BR), .BG(BG),
    .d_address(d_address), .d_writeM(d_writeM), .d_data(d_data), .dev_data(dev_data),
    .dev_ack(dev_ack), .busy(busy), .dma_end_int(dma_end_int)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned   kind;     // 0 = line ack, 1 = end interrupt
    int unsigned   ch;
    logic [W-1:0]  addr;
    logic [LB-1:0] data;
    logic [LB-1:0] exp_data;
    logic          busy_bit;
  } ev_t;

  ev_t          obs_q[$];
  ev_t          exp_q[$];
  logic [W-1:0] wm_addr_q[$];
  int unsigned  wm_count;
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [N-1:0] adv_pending = '0;
  logic         bg_auto = 1'b1;
  logic         br_d = 1'b0;
  logic [W-1:0] m_addr [N];
  int unsigned  m_len  [N];

  // Bus owner: BG follows BR one cycle later while bg_auto is set.
  initial begin
    forever begin
      @(negedge Clk);
      if (bg_auto) BG = br_d;
      br_d = BR;
    end
  end

  // Observer and device model: device presents a fresh line the cycle after its ack.
  initial begin
    ev_t e;
    forever begin
      @(posedge Clk);
      #1;
      for (int c = 0; c < N; c++)
        if (adv_pending[c]) dev_data[c*LB +: LB] = {$urandom, $urandom};
      adv_pending = '0;
      if (d_writeM === 1'b1) begin
        wm_count++;
        wm_addr_q.push_back(d_address);
      end
      for (int c = 0; c < N; c++) begin
        if (dev_ack[c] === 1'b1) begin
          e.kind = 0; e.ch = c; e.addr = d_address; e.data = d_data;
          e.exp_data = dev_data[c*LB +: LB]; e.busy_bit = 1'b0;
          obs_q.push_back(e);
          adv_pending[c] = 1'b1;
        end
        if (dma_end_int[c] === 1'b1) begin
          e.kind = 1; e.ch = c; e.addr = '0; e.data = '0; e.exp_data = '0;
          e.busy_bit = busy[c];
          obs_q.push_back(e);
        end
      end
    end
  end

  function automatic string ev_str(input ev_t e);
    return $sformatf("%s ch%0d @%h", (e.kind == 0) ? "ack" : "end", e.ch, e.addr);
  endfunction

  // Line-level model: grants go round-robin from the first-issued channel,
  // each grant writing min(MAX_BURST, remaining) consecutive lines.
  task automatic model_build(input int unsigned first_ch);
    logic [W-1:0] a [N];
    int unsigned  r [N];
    int unsigned  last, c, take;
    bit           found;
    ev_t          e;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin a[i] = m_addr[i]; r[i] = m_len[i]; end
    last = (first_ch + N - 1) % N;
    for (int g = 0; g < 1000; g++) begin
      found = 0; c = 0;
      for (int k = 1; k <= N; k++)
        if (!found && r[(last + k) % N] > 0) begin found = 1; c = (last + k) % N; end
      if (!found) break;
      take = (r[c] < MB) ? r[c] : MB;
      for (int k = 0; k < int'(take); k++) begin
        e.kind = 0; e.ch = c; e.addr = a[c]; e.data = '0; e.exp_data = '0; e.busy_bit = 1'b0;
        exp_q.push_back(e);
        a[c] = a[c] + W'(LW);
        r[c]--;
        if (r[c] == 0) begin e.kind = 1; e.addr = '0; exp_q.push_back(e); end
      end
      last = c;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); wm_addr_q.delete(); wm_count = 0; adv_pending = '0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; bg_auto = 1'b1;
    @(negedge Clk); Reset_N = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
    clear_obs();
  endtask

  task automatic issue(input int unsigned ch, input logic [W-1:0] a, input logic [W-1:0] l);
    @(negedge Clk);
    cmd_valid = 1'b1; cmd_ch = 1'(ch); cmd_addr = a; cmd_len = l;
    @(negedge Clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, output bit ok);
    ok = 0;
    for (int i = 0; i < int'(limit); i++) begin
      @(negedge Clk);
      if (obs_q.size() >= exp_q.size() && busy === '0 && BR === 1'b0) begin ok = 1; break; end
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_N = 1'b1; #2; Reset_N = 1'b0; #2;
    n_checks++;
    if ({BR, d_writeM} !== 2'b00) begin n_fail++; $display("FAIL reset_br_wm: got %b required 00", {BR, d_writeM}); end
    n_checks++;
    if (d_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", d_address); end
    n_checks++;
    if (d_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h required 0", d_data); end
    n_checks++;
    if ({dev_ack, busy, dma_end_int} !== '0) begin n_fail++; $display("FAIL reset_vec: got %b required 0", {dev_ack, busy, dma_end_int}); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    m_addr[0] = 16'h0100; m_len[0] = 2; m_addr[1] = '0; m_len[1] = 0;
    model_build(0);
    issue(0, 16'h0100, 16'd2);
    n_checks++;
    if ({busy[0], BR, cmd_ready} !== 3'b100) begin n_fail++; $display("FAIL single_accept: busy/BR/ready got %b required 100", {busy[0], BR, cmd_ready}); end
    @(posedge Clk); #1;
    n_checks++;
    if (BR !== 1'b1) begin n_fail++; $display("FAIL single_br_rise: got %b required 1", BR); end
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got timeout required completion"); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_evcount: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
          (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
        n_fail++; $display("FAIL single_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
      end
    end
    n_checks++;
    if (wm_count !== 8) begin n_fail++; $display("FAIL single_wm_cycles: got %0d required 8", wm_count); end
    foreach (wm_addr_q[i]) begin
      n_checks++;
      if (wm_addr_q[i] !== W'(16'h0100 + (i / 4) * 4)) begin
        n_fail++; $display("FAIL single_wm_addr%0d: got %h required %h", i, wm_addr_q[i], W'(16'h0100 + (i / 4) * 4));
      end
    end
    n_checks++;
    if (BR !== 1'b0) begin n_fail++; $display("FAIL single_br_after: got %b required 0", BR); end
  endtask

  task automatic test_two_channel();
    bit ok;
    do_reset();
    m_addr[0] = 16'h1000; m_len[0] = 6; m_addr[1] = 16'h2000; m_len[1] = 1;
    model_build(0);
    issue(0, 16'h1000, 16'd6);
    issue(1, 16'h2000, 16'd1);
    wait_done(500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL two_timeout: got timeout required completion"); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL two_evcount: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
          (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
        n_fail++; $display("FAIL two_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
      end
    end
    n_checks++;
    if (wm_count !== 7 * ML) begin n_fail++; $display("FAIL two_wm_cycles: got %0d required %0d", wm_count, 7 * ML); end
  endtask

  task automatic test_len0();
    int unsigned br_seen;
    do_reset();
    issue(1, 16'h3000, 16'd0);
    n_checks++;
    if ({dma_end_int, busy} !== 4'b1000) begin n_fail++; $display("FAIL len0_pulse: end/busy got %b required 1000", {dma_end_int, busy}); end
    br_seen = 0;
    @(negedge Clk);
    n_checks++;
    if (dma_end_int !== 2'b00) begin n_fail++; $display("FAIL len0_width: got %b required 00", dma_end_int); end
    for (int i = 0; i < 10; i++) begin
      if (BR === 1'b1 || busy[1] !== 1'b0) br_seen++;
      @(negedge Clk);
    end
    n_checks++;
    if (br_seen !== 0) begin n_fail++; $display("FAIL len0_no_br: got %0d cycles with BR/busy required 0", br_seen); end
  endtask

  task automatic test_bg_drop();
    bit ok;
    int unsigned seen;
    do_reset();
    bg_auto = 1'b0; BG = 1'b0;
    m_addr[0] = 16'h0200; m_len[0] = 1; m_addr[1] = '0; m_len[1] = 0;
    model_build(0);
    issue(0, 16'h0200, 16'd1);
    for (int i = 0; i < 20 && BR !== 1'b1; i++) @(negedge Clk);
    BG = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      @(negedge Clk);
      if (d_writeM === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 3) begin n_fail++; $display("FAIL drop_beats: got %0d required 3", seen); end
    BG = 1'b0;
    #1;
    n_checks++;
    if ({d_writeM, dev_ack} !== 3'b000) begin n_fail++; $display("FAIL drop_gate: wm/ack got %b required 000", {d_writeM, dev_ack}); end
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({BR, wm_count[3:0]} !== {1'b1, 4'd3} || obs_q.size() !== 0) begin
      n_fail++; $display("FAIL drop_rereq: BR %b wm %0d events %0d required 1 3 0", BR, wm_count, obs_q.size());
    end
    bg_auto = 1'b1;
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop_timeout: got timeout required completion"); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL drop_evcount: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
          (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
        n_fail++; $display("FAIL drop_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
      end
    end
    n_checks++;
    if (wm_count !== 7) begin n_fail++; $display("FAIL drop_wm_cycles: got %0d required 7", wm_count); end
    foreach (wm_addr_q[i]) begin
      n_checks++;
      if (wm_addr_q[i] !== 16'h0200) begin n_fail++; $display("FAIL drop_wm_addr%0d: got %h required 0200", i, wm_addr_q[i]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    m_addr[0] = 16'hFFFC; m_len[0] = 2; m_addr[1] = '0; m_len[1] = 0;
    model_build(0);
    issue(0, 16'hFFFC, 16'd2);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got timeout required completion"); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_evcount: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
          (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
        n_fail++; $display("FAIL wrap_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    issue(0, 16'h0400, 16'd3);
    for (int i = 0; i < 30 && d_writeM !== 1'b1; i++) @(negedge Clk);
    #2;
    Reset_N = 1'b0;
    #1;
    n_checks++;
    if ({BR, d_writeM, dev_ack, busy, dma_end_int} !== '0 || d_address !== '0 || d_data !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: BR %b wm %b addr %h ack %b busy %b end %b required all 0",
                         BR, d_writeM, d_address, dev_ack, busy, dma_end_int);
    end
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    clear_obs();
    repeat (6) @(negedge Clk);
    n_checks++;
    if (busy !== 2'b00 || obs_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_quiet: busy %b events %0d required 00 0", busy, obs_q.size());
    end
    m_addr[0] = '0; m_len[0] = 0; m_addr[1] = 16'h0500; m_len[1] = 1;
    model_build(1);
    issue(1, 16'h0500, 16'd1);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_timeout: got timeout required completion"); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset_evcount: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
          (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
        n_fail++; $display("FAIL midreset_ev%0d: got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int unsigned f;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      f = $urandom_range(0, 1);
      for (int c = 0; c < N; c++) begin
        m_addr[c] = W'($urandom);
        m_len[c]  = $urandom_range(1, 7);
      end
      model_build(f);
      issue(f, m_addr[f], W'(m_len[f]));
      issue(1 - f, m_addr[1 - f], W'(m_len[1 - f]));
      wait_done(1000, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout required completion", it); end
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_evcount: got %0d required %0d", it, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_checks++;
        if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].ch !== exp_q[i].ch || obs_q[i].addr !== exp_q[i].addr ||
            (obs_q[i].kind == 0 && obs_q[i].data !== obs_q[i].exp_data) || obs_q[i].busy_bit !== 1'b0) begin
          n_fail++; $display("FAIL rand%0d_ev%0d: got %s required %s", it, i, ev_str(obs_q[i]), ev_str(exp_q[i]));
        end
      end
      n_checks++;
      if (wm_count !== (m_len[0] + m_len[1]) * ML) begin
        n_fail++; $display("FAIL rand%0d_wm_cycles: got %0d required %0d", it, wm_count, (m_len[0] + m_len[1]) * ML);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++) dev_data[c*LB +: LB] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_two_channel();
    test_len0();
    test_bg_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
